rv32v_scalar_wb_queue: RTL and testbench

- Parametrised buffer for vector-unit results that target the scalar register file (vmv.x.s, vsetvl rd, vcpop, vfirst).
- Sits between the RV32V execute stage and the scalar writeback port.
- Holds results in FIFO order until the scalar pipeline grants a write slot.
- Exposes a pending-rd scoreboard so scalar decode can stall on RAW hazards, and drops all pending results on exception return.

---
 rtl/rv32v_scalar_wb_queue.sv | 159 +++++++++++++++
 tb/tb_rv32v_scalar_wb_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32v_scalar_wb_queue.sv
// rv32v_scalar_wb_queue
//   FIFO buffer for vector-unit results that target the scalar register file
//   (vmv.x.s, vsetvl rd, vcpop, vfirst). It sits between the RV32V execute
//   stage and the scalar writeback port, and it holds results in order until
//   the scalar pipeline grants a write slot. A pending-rd scoreboard lets
//   scalar decode stall on RAW hazards. A flush (exception return) discards
//   every pending result.
//
//   Optional feature: define RV32V_WB_BYPASS_EN to let a result pass straight
//   through to the writeback port in the same cycle when the queue is empty.
//   In the default build this is off, and the minimum latency is one cycle.
//
// Ports
//   CLK, RST             clock, synchronous active-high reset
//   enq_valid/enq_ready  result handshake from the vector unit
//   enq_rd_sel/enq_data  destination register and value of the result
//   wb_ready             scalar writeback port is free this cycle
//   rd_wen/rd_sel/rd_data  scalar regfile write port
//   flush                exception return; drop all pending results
//   rs1_sel/rs2_sel      decode source indices
//   rs1_busy/rs2_busy    the matching source has a queued write
//   count/full/empty     occupancy status
//
// Handshake: a transfer happens in any cycle where valid && ready is high.
// The ready signal never depends on valid in the same cycle. enq_ready is
// taken only from the registered full flag and from flush, so a dequeue in
// the same cycle does not open a slot for an enqueue.

module rv32v_scalar_wb_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [4:0]        enq_rd_sel,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              wb_ready,
    output logic              rd_wen,
    output logic [4:0]        rd_sel,
    output logic [DATA_W-1:0] rd_data,
    input  logic              flush,
    input  logic [4:0]        rs1_sel,
    input  logic [4:0]        rs2_sel,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic              valid_q [DEPTH];
    logic              valid_d [DEPTH];
    logic [4:0]        sel_q   [DEPTH];
    logic [4:0]        sel_d   [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic deq_fire;
    logic byp_fire;
    logic store;

    // Handshake and port outputs
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        count     = count_q;
        enq_ready = !full && !flush;
        deq_fire  = !empty && wb_ready && !flush;
        byp_fire  = 1'b0;
`ifdef RV32V_WB_BYPASS_EN
        byp_fire  = empty && enq_valid && wb_ready && !flush && (enq_rd_sel != 5'd0);
`endif
        // Writes to x0 complete the handshake but are never stored.
        store     = enq_valid && enq_ready && (enq_rd_sel != 5'd0) && !byp_fire;
        rd_wen    = deq_fire || byp_fire;
        rd_sel    = 5'd0;
        rd_data   = '0;
        if (!empty) begin
            rd_sel  = sel_q[rd_ptr_q];
            rd_data = data_q[rd_ptr_q];
        end else if (byp_fire) begin
            rd_sel  = enq_rd_sel;
            rd_data = enq_data;
        end
    end

    // Pending-rd scoreboard. It uses only the registered entries, so an
    // enqueue shows up one cycle later. The head entry still reads as busy
    // in the cycle it is written back.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (sel_q[i] == rs1_sel)) rs1_busy = 1'b1;
            if (valid_q[i] && (sel_q[i] == rs2_sel)) rs2_busy = 1'b1;
        end
        if (rs1_sel == 5'd0) rs1_busy = 1'b0;
        if (rs2_sel == 5'd0) rs2_busy = 1'b0;
    end

    // Next-state logic. flush wins over enqueue and dequeue.
    always_comb begin
        valid_d  = valid_q;
        sel_d    = sel_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) valid_d[i] = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (deq_fire) begin
                valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            end
            if (store) begin
                valid_d[wr_ptr_q] = 1'b1;
                sel_d[wr_ptr_q]   = enq_rd_sel;
                data_d[wr_ptr_q]  = enq_data;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (store && !deq_fire) begin
                count_d = count_q + CNT_W'(1);
            end else if (!store && deq_fire) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q  <= '{default: 1'b0};
            sel_q    <= '{default: 5'd0};
            data_q   <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_rv32v_scalar_wb_queue.sv
// Testbench for rv32v_scalar_wb_queue. The bench runs a set of directed
// scenarios and then a long random phase. A queue-based reference model
// predicts every output in every cycle.

module tb_rv32v_scalar_wb_queue;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int W      = 5 + DATA_W;

    logic              clk;
    logic              rst;
    logic              enq_valid;
    logic              enq_ready;
    logic [4:0]        enq_rd_sel;
    logic [DATA_W-1:0] enq_data;
    logic              wb_ready;
    logic              rd_wen;
    logic [4:0]        rd_sel;
    logic [DATA_W-1:0] rd_data;
    logic              flush;
    logic [4:0]        rs1_sel;
    logic [4:0]        rs2_sel;
    logic              rs1_busy;
    logic              rs2_busy;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    rv32v_scalar_wb_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK(clk), .RST(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_rd_sel(enq_rd_sel), .enq_data(enq_data),
        .wb_ready(wb_ready),
        .rd_wen(rd_wen), .rd_sel(rd_sel), .rd_data(rd_data),
        .flush(flush),
        .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .count(count), .full(full), .empty(empty)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state: the pending results in order, as {rd, data}
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic pending(input logic [4:0] r);
        logic hit;
        hit = 1'b0;
        if (r != 5'd0) begin
            foreach (exp_q[i]) if (exp_q[i][W-1:DATA_W] == r) hit = 1'b1;
        end
        return hit;
    endfunction

    // Driver: apply one cycle of inputs (called at the falling edge)
    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                         input logic wbr, input logic fl,
                         input logic [4:0] r1, input logic [4:0] r2);
        enq_valid  = v;
        enq_rd_sel = rd;
        enq_data   = d;
        wb_ready   = wbr;
        flush      = fl;
        rs1_sel    = r1;
        rs2_sel    = r2;
    endtask

    // Check this cycle's outputs against the model, then advance the model
    // at the rising edge. The task returns at the next falling edge.
    task automatic step();
        int   n;
        logic e_empty, e_full, e_ready, e_byp, e_deq, e_wen;
        logic [4:0]        e_sel;
        logic [DATA_W-1:0] e_data;
        #1;
        n       = exp_q.size();
        e_empty = (n == 0);
        e_full  = (n == DEPTH);
        e_ready = !e_full && !flush;
        e_byp   = 1'b0;
`ifdef RV32V_WB_BYPASS_EN
        e_byp   = e_empty && enq_valid && wb_ready && !flush && (enq_rd_sel != 5'd0);
`endif
        e_deq   = !e_empty && wb_ready && !flush;
        e_wen   = e_deq || e_byp;
        e_sel   = 5'd0;
        e_data  = '0;
        if (n > 0) begin
            e_sel  = exp_q[0][W-1:DATA_W];
            e_data = exp_q[0][DATA_W-1:0];
        end else if (e_byp) begin
            e_sel  = enq_rd_sel;
            e_data = enq_data;
        end
        if (!rst) begin
            check("count",     32'(count),     32'(n));
            check("empty",     32'(empty),     32'(e_empty));
            check("full",      32'(full),      32'(e_full));
            check("enq_ready", 32'(enq_ready), 32'(e_ready));
            check("rd_wen",    32'(rd_wen),    32'(e_wen));
            check("rd_sel",    32'(rd_sel),    32'(e_sel));
            check("rd_data",   32'(rd_data),   32'(e_data));
            check("rs1_busy",  32'(rs1_busy),  32'(pending(rs1_sel)));
            check("rs2_busy",  32'(rs2_busy),  32'(pending(rs2_sel)));
        end
        @(posedge clk);
        cyc++;
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (e_deq) void'(exp_q.pop_front());
            if (enq_valid && e_ready && enq_rd_sel != 5'd0 && !e_byp)
                exp_q.push_back({enq_rd_sel, enq_data});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic wbr, input logic [4:0] r1, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(1'b0, 5'd0, 32'h0, wbr, 1'b0, r1, 5'd0);
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state while the inputs are idle
        idle(1'b0, 5'd0, 1);

        // Fill to full with writeback stalled, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(5 + i), 32'(8'h11 * (i + 1)), 1'b0, 1'b0, 5'd6, 5'd8);
            step();
        end
        idle(1'b0, 5'd6, 1);
        idle(1'b1, 5'd6, 5);

        // A write to x0 is accepted and dropped
        drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 1'b0, 5'd0, 5'd0);
        step();
        idle(1'b1, 5'd0, 2);

        // Two writes to the same rd retire in order
        drive(1'b1, 5'd9, 32'h1, 1'b0, 1'b0, 5'd9, 5'd0);
        step();
        drive(1'b1, 5'd9, 32'h2, 1'b0, 1'b0, 5'd9, 5'd0);
        step();
        idle(1'b1, 5'd9, 3);

        // Flush while three entries are held and an enqueue is presented
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(10 + i), 32'(i + 100), 1'b0, 1'b0, 5'd10, 5'd12);
            step();
        end
        drive(1'b1, 5'd13, 32'hBEEF, 1'b1, 1'b1, 5'd10, 5'd13);
        step();
        idle(1'b1, 5'd10, 3);

        // Enqueue into an empty queue with writeback free (bypass case)
        drive(1'b1, 5'd3, 32'hAB, 1'b1, 1'b0, 5'd3, 5'd0);
        step();
        idle(1'b1, 5'd3, 2);

        // Random traffic, with one reset in the middle of the run
        for (int i = 0; i < 600; i++) begin
            rst = (i == 300);
            drive($urandom_range(0, 9) < 7,
                  5'($urandom_range(0, 7)),
                  $urandom,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 39) == 0,
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
            step();
        end
        rst = 1'b0;
        idle(1'b1, 5'd0, 6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
